ysyx_23060124_ifu: RTL

//   Instruction fetch unit: single-outstanding fetch over an AXI4-Lite read channel.

---
 rtl/ysyx_23060124_ifu.sv | 123 ++++++++++++
 1 files changed

// File: rtl/ysyx_23060124_ifu.sv
// rtl/ysyx_23060124_ifu.sv - single-outstanding AXI4-Lite instruction fetch unit
// Optional YSYX_23060124_IFU_PERF_EN adds o_fetch_cnt / o_stall_cnt counters.
module ysyx_23060124_ifu #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h3000_0000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] i_pc_next,
  input  logic              i_pc_update,
  output logic [ADDR_W-1:0] o_araddr,
  output logic              o_arvalid,
  input  logic              i_arready,
  input  logic [31:0]       i_rdata,
  input  logic [1:0]        i_rresp,
  input  logic              i_rvalid,
  output logic              o_rready,
  output logic [ADDR_W-1:0] o_pc,
  output logic [31:0]       o_inst,
  output logic              o_fetch_err,
  output logic              o_post_valid,
  input  logic              i_post_ready
`ifdef YSYX_23060124_IFU_PERF_EN
  ,
  output logic [31:0]       o_fetch_cnt,
  output logic [31:0]       o_stall_cnt
`endif
);

  localparam logic [1:0] S_ADDR  = 2'd0;
  localparam logic [1:0] S_DATA  = 2'd1;
  localparam logic [1:0] S_VALID = 2'd2;
  localparam logic [1:0] S_WAIT  = 2'd3;

  logic [1:0]        state;
  logic              pend;
  logic [ADDR_W-1:0] pend_pc;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;

  // A redirect arriving this cycle overrides any older pending one.
  assign redirect    = pend || i_pc_update;
  assign redirect_pc = i_pc_update ? i_pc_next : pend_pc;

  assign o_araddr     = {o_pc[ADDR_W-1:2], 2'b00};
  assign o_rready     = (state == S_DATA);
  assign o_post_valid = (state == S_VALID);

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_ADDR;
      o_pc        <= RESET_PC;
      o_inst      <= 32'h0;
      o_fetch_err <= 1'b0;
      o_arvalid   <= 1'b0;
      pend        <= 1'b0;
      pend_pc     <= '0;
    end else begin
      case (state)
        S_ADDR: begin
          if (i_pc_update) begin
            pend    <= 1'b1;
            pend_pc <= i_pc_next;
          end
          // AR is never withdrawn once raised; a redirect waits for the beat.
          if (o_arvalid && i_arready) begin
            o_arvalid <= 1'b0;
            state     <= S_DATA;
          end else begin
            o_arvalid <= 1'b1;
          end
        end
        S_DATA: begin
          if (i_pc_update) begin
            pend    <= 1'b1;
            pend_pc <= i_pc_next;
          end
          if (i_rvalid) begin
            if (redirect) begin
              o_pc  <= redirect_pc;
              pend  <= 1'b0;
              state <= S_ADDR;
            end else begin
              o_inst      <= i_rdata;
              o_fetch_err <= (i_rresp != 2'b00) || (o_pc[1:0] != 2'b00);
              state       <= S_VALID;
            end
          end
        end
        S_VALID: begin
          if (redirect) begin
            o_pc  <= redirect_pc;
            pend  <= 1'b0;
            state <= S_ADDR;
          end else if (i_post_ready) begin
            state <= S_WAIT;
          end
        end
        default: begin
          if (i_pc_update) begin
            o_pc  <= i_pc_next;
            state <= S_ADDR;
          end
        end
      endcase
    end
  end

`ifdef YSYX_23060124_IFU_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      o_fetch_cnt <= 32'h0;
      o_stall_cnt <= 32'h0;
    end else begin
      if (o_post_valid && i_post_ready)
        o_fetch_cnt <= o_fetch_cnt + 32'd1;
      if (state == S_ADDR || state == S_DATA)
        o_stall_cnt <= o_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
